// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the I/D-cache to block-memory arbiter.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 28;
    localparam int MEM_DATA_W = 128;

    // Grant state; the encoding is fixed so other tools can decode it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    // A port is requesting whenever either of its strobes is high.
    function automatic logic port_req(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One block-memory request/response channel (cache side or memory side).
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                  read;
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_DATA_W-1:0] rdata;
    logic                  ready;

    // Requestor: issues accesses and receives data/completion.
    modport master (
        output read, write, addr, wdata,
        input  rdata, ready
    );

    // Responder: accepts accesses and returns data/completion.
    modport slave (
        input  read, write, addr, wdata,
        output rdata, ready
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Stall watchdog: counts granted cycles without a memory completion and
// raises a sticky error once the count reaches TIMEOUT (0 disables it).
module mem_arb_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic proc_reset,
    input  logic busy,
    input  logic restart,
    input  logic mem_ready,
    output logic mem_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          err_reg;

    // Next count: clear on a new grant or a completion, else count up and saturate.
    always_comb begin
        count_next = count_reg;
        if (restart || (busy && mem_ready)) begin
            count_next = '0;
        end else if (busy && (count_reg != LIMIT)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Counter and sticky error; the error is taken from the next count so it
    // is visible in the very cycle the count reaches TIMEOUT.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            count_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            if ((TIMEOUT != 0) && busy && (count_next == LIMIT)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign mem_err = err_reg;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 128-bit block-memory port between the I-cache and D-cache.
// Alternates on contention and keeps the grant across a write-back so the
// following refill read is never split from its victim write.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          proc_reset,
    mem_arbiter_if.slave  ic_mem,
    mem_arbiter_if.slave  dc_mem,
    mem_arbiter_if.master mem,
    output logic          mem_err
);

    arb_state_t state_reg;
    logic       last_reg;   // most recent grantee: 0 = I, 1 = D

    logic ic_req;
    logic dc_req;
    logic restart;
    logic busy;

    assign ic_req  = port_req(ic_mem.read, ic_mem.write);
    assign dc_req  = port_req(dc_mem.read, dc_mem.write);
    assign restart = (state_reg == IDLE) && (ic_req || dc_req);
    assign busy    = (state_reg != IDLE);

    // Grant FSM: arbitrate from IDLE, release after a read completes or the
    // owner withdraws, stay granted after a completed write.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_reg <= IDLE;
            last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ic_req && dc_req) begin
                        if (last_reg) begin
                            state_reg <= GNT_I;
                            last_reg  <= 1'b0;
                        end else begin
                            state_reg <= GNT_D;
                            last_reg  <= 1'b1;
                        end
                    end else if (ic_req) begin
                        state_reg <= GNT_I;
                        last_reg  <= 1'b0;
                    end else if (dc_req) begin
                        state_reg <= GNT_D;
                        last_reg  <= 1'b1;
                    end
                end
                GNT_I: begin
                    if (mem.ready) begin
                        if (!ic_mem.write) state_reg <= IDLE;
                    end else if (!ic_req) begin
                        state_reg <= IDLE;
                    end
                end
                GNT_D: begin
                    if (mem.ready) begin
                        if (!dc_mem.write) state_reg <= IDLE;
                    end else if (!dc_req) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Steering: the owner's request reaches memory and only the owner sees
    // the completion strobe; everything else reads 0.
    always_comb begin
        mem.read     = 1'b0;
        mem.write    = 1'b0;
        mem.addr     = '0;
        mem.wdata    = '0;
        ic_mem.ready = 1'b0;
        dc_mem.ready = 1'b0;
        case (state_reg)
            GNT_I: begin
                mem.read     = ic_mem.read;
                mem.write    = ic_mem.write;
                mem.addr     = ic_mem.addr;
                mem.wdata    = ic_mem.wdata;
                ic_mem.ready = mem.ready;
            end
            GNT_D: begin
                mem.read     = dc_mem.read;
                mem.write    = dc_mem.write;
                mem.addr     = dc_mem.addr;
                mem.wdata    = dc_mem.wdata;
                dc_mem.ready = mem.ready;
            end
            default: ;
        endcase
    end

    // Read data is broadcast; the ready strobe alone tells a cache it is valid.
    assign ic_mem.rdata = mem.rdata;
    assign dc_mem.rdata = mem.rdata;

    mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .proc_reset(proc_reset),
        .busy      (busy),
        .restart   (restart),
        .mem_ready (mem.ready),
        .mem_err   (mem_err)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-scenario tasks, per-port
// scoreboards of expected memory-side requests.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk;
    logic proc_reset;
    logic mem_err;
    logic mem_err0;

    mem_arbiter_if ic_if ();
    mem_arbiter_if dc_if ();
    mem_arbiter_if mem_if ();
    mem_arbiter_if ic0_if ();
    mem_arbiter_if dc0_if ();
    mem_arbiter_if mem0_if ();

    mem_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .ic_mem(ic_if), .dc_mem(dc_if), .mem(mem_if), .mem_err(mem_err)
    );

    mem_arbiter #(.TIMEOUT(0)) dut0 (
        .clk(clk), .proc_reset(proc_reset),
        .ic_mem(ic0_if), .dc_mem(dc0_if), .mem(mem0_if), .mem_err(mem_err0)
    );

    typedef struct packed {
        logic                  wr;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } req_t;

    req_t ic_q[$];
    req_t dc_q[$];
    req_t e;
    int   checks   = 0;
    int   failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    // Advance to the drive point just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ic_if.read = 0;  ic_if.write = 0;  ic_if.addr = '0;  ic_if.wdata = '0;
        dc_if.read = 0;  dc_if.write = 0;  dc_if.addr = '0;  dc_if.wdata = '0;
        mem_if.ready = 0; mem_if.rdata = '0;
        ic0_if.read = 0; ic0_if.write = 0; ic0_if.addr = '0; ic0_if.wdata = '0;
        dc0_if.read = 0; dc0_if.write = 0; dc0_if.addr = '0; dc0_if.wdata = '0;
        mem0_if.ready = 0; mem0_if.rdata = '0;
    endtask

    task automatic do_reset();
        step();
        proc_reset = 1;
        clear_inputs();
        step();
        step();
        proc_reset = 0;
    endtask

    task automatic test_reset();
        step();
        proc_reset = 1;
        clear_inputs();
        ic_if.read = 1; ic_if.addr = 28'h0000011;
        mem_if.rdata = {4{32'hDEADBEEF}};
        step();
        step();
        #4;
        checks++; if (mem_if.read !== 1'b0) begin failures++; $display("FAIL rst_mem_read: got %b required 0", mem_if.read); end
        checks++; if (mem_if.write !== 1'b0) begin failures++; $display("FAIL rst_mem_write: got %b required 0", mem_if.write); end
        checks++; if (mem_if.addr !== 28'h0) begin failures++; $display("FAIL rst_mem_addr: got %h required 0", mem_if.addr); end
        checks++; if ({ic_if.ready, dc_if.ready} !== 2'b00) begin failures++; $display("FAIL rst_ready: got %b required 00", {ic_if.ready, dc_if.ready}); end
        checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL rst_mem_err: got %b required 0", mem_err); end
        checks++; if ((ic_if.rdata !== {4{32'hDEADBEEF}}) || (dc_if.rdata !== {4{32'hDEADBEEF}})) begin
            failures++; $display("FAIL rst_rdata: got ic=%h dc=%h required %h", ic_if.rdata, dc_if.rdata, {4{32'hDEADBEEF}});
        end
        step();
        proc_reset = 0;
        clear_inputs();
    endtask

    task automatic test_single_read();
        do_reset();
        step();  // cycle 0
        ic_if.read = 1; ic_if.addr = 28'h0000010;
        ic_q.push_back('{wr: 1'b0, addr: 28'h0000010, wdata: '0});
        #4;
        checks++; if (mem_if.read !== 1'b0) begin failures++; $display("FAIL single_c0_latency: got mem_read=%b required 0", mem_if.read); end
        step();  // cycle 1
        #4;
        checks++;
        if (ic_q.size() == 0) begin failures++; $display("FAIL single_sb: got grant, required a queued I entry"); end
        else begin
            e = ic_q.pop_front();
            if ({mem_if.read, mem_if.write, mem_if.addr, mem_if.wdata} !== {~e.wr, e.wr, e.addr, e.wdata}) begin
                failures++; $display("FAIL single_grant: got rd=%b wr=%b addr=%h required rd=%b wr=%b addr=%h", mem_if.read, mem_if.write, mem_if.addr, ~e.wr, e.wr, e.addr);
            end else $display("txn I %s addr=%h", e.wr ? "write" : "read", e.addr);
        end
        repeat (4) step();  // cycle 5
        mem_if.ready = 1; mem_if.rdata = {16{8'hA5}};
        #4;
        checks++; if ({ic_if.ready, dc_if.ready} !== 2'b10) begin failures++; $display("FAIL single_ready: got ic/dc=%b required 10", {ic_if.ready, dc_if.ready}); end
        checks++; if (ic_if.rdata !== {16{8'hA5}}) begin failures++; $display("FAIL single_rdata: got %h required %h", ic_if.rdata, {16{8'hA5}}); end
        step();  // cycle 6
        mem_if.ready = 0; ic_if.read = 0;
        #4;
        checks++; if (mem_if.read !== 1'b0) begin failures++; $display("FAIL single_idle: got mem_read=%b required 0", mem_if.read); end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int c = 0; c <= 18; c++) begin
            step();
            case (c)
                0: begin
                    ic_if.read = 1; ic_if.addr = 28'h0000200;
                    dc_if.read = 1; dc_if.addr = 28'h0000300;
                    ic_q.push_back('{wr: 1'b0, addr: 28'h0000200, wdata: '0});
                    dc_q.push_back('{wr: 1'b0, addr: 28'h0000300, wdata: '0});
                end
                3, 6, 9, 13, 16: mem_if.ready = 1;
                4:  begin mem_if.ready = 0; dc_if.read = 0; end
                7:  begin
                    mem_if.ready = 0; ic_if.read = 0;
                    dc_if.read = 1; dc_if.addr = 28'h0000340;
                    dc_q.push_back('{wr: 1'b0, addr: 28'h0000340, wdata: '0});
                end
                10: begin mem_if.ready = 0; dc_if.read = 0; end
                11: begin
                    ic_if.read = 1; ic_if.addr = 28'h0000240;
                    dc_if.read = 1; dc_if.addr = 28'h0000380;
                    ic_q.push_back('{wr: 1'b0, addr: 28'h0000240, wdata: '0});
                    dc_q.push_back('{wr: 1'b0, addr: 28'h0000380, wdata: '0});
                end
                14: begin mem_if.ready = 0; ic_if.read = 0; end
                17: begin mem_if.ready = 0; dc_if.read = 0; end
                default: ;
            endcase
            #4;
            if ((c == 1) || (c == 8) || (c == 15)) begin
                checks++;
                if (dc_q.size() == 0) begin failures++; $display("FAIL simul_sb_d c%0d: got grant, required a queued D entry", c); end
                else begin
                    e = dc_q.pop_front();
                    if ({mem_if.read, mem_if.write, mem_if.addr} !== {~e.wr, e.wr, e.addr}) begin
                        failures++; $display("FAIL simul_grant_d c%0d: got rd=%b wr=%b addr=%h required rd=%b wr=%b addr=%h", c, mem_if.read, mem_if.write, mem_if.addr, ~e.wr, e.wr, e.addr);
                    end else $display("txn D read addr=%h cycle=%0d", e.addr, c);
                end
            end
            if ((c == 5) || (c == 12)) begin
                checks++;
                if (ic_q.size() == 0) begin failures++; $display("FAIL simul_sb_i c%0d: got grant, required a queued I entry", c); end
                else begin
                    e = ic_q.pop_front();
                    if ({mem_if.read, mem_if.write, mem_if.addr} !== {~e.wr, e.wr, e.addr}) begin
                        failures++; $display("FAIL simul_grant_i c%0d: got rd=%b wr=%b addr=%h required rd=%b wr=%b addr=%h", c, mem_if.read, mem_if.write, mem_if.addr, ~e.wr, e.wr, e.addr);
                    end else $display("txn I read addr=%h cycle=%0d", e.addr, c);
                end
            end
            if (c == 3) begin
                checks++; if ({ic_if.ready, dc_if.ready} !== 2'b01) begin failures++; $display("FAIL simul_ready_d: got ic/dc=%b required 01", {ic_if.ready, dc_if.ready}); end
            end
            if ((c == 4) || (c == 7)) begin
                checks++; if (mem_if.read !== 1'b0) begin failures++; $display("FAIL simul_gap c%0d: got mem_read=%b required 0", c, mem_if.read); end
            end
        end
        clear_inputs();
    endtask

    task automatic test_writeback_refill();
        do_reset();
        for (int c = 0; c <= 11; c++) begin
            step();
            case (c)
                0: begin
                    dc_if.write = 1; dc_if.addr = 28'h0ABCDE0; dc_if.wdata = {4{32'h12345678}};
                    ic_if.read = 1;  ic_if.addr = 28'h0000040;
                    dc_q.push_back('{wr: 1'b1, addr: 28'h0ABCDE0, wdata: {4{32'h12345678}}});
                    ic_q.push_back('{wr: 1'b0, addr: 28'h0000040, wdata: '0});
                end
                4, 7, 10: mem_if.ready = 1;
                5: begin
                    mem_if.ready = 0;
                    dc_if.write = 0; dc_if.wdata = '0;
                    dc_if.read = 1;  dc_if.addr = 28'h0000120;
                    dc_q.push_back('{wr: 1'b0, addr: 28'h0000120, wdata: '0});
                end
                8:  begin mem_if.ready = 0; dc_if.read = 0; end
                11: begin mem_if.ready = 0; ic_if.read = 0; end
                default: ;
            endcase
            #4;
            if ((c == 1) || (c == 5)) begin
                checks++;
                if (dc_q.size() == 0) begin failures++; $display("FAIL wb_sb_d c%0d: got grant, required a queued D entry", c); end
                else begin
                    e = dc_q.pop_front();
                    if ({mem_if.read, mem_if.write, mem_if.addr, mem_if.wdata} !== {~e.wr, e.wr, e.addr, e.wdata}) begin
                        failures++; $display("FAIL wb_grant_d c%0d: got rd=%b wr=%b addr=%h wdata=%h required rd=%b wr=%b addr=%h wdata=%h", c, mem_if.read, mem_if.write, mem_if.addr, mem_if.wdata, ~e.wr, e.wr, e.addr, e.wdata);
                    end else $display("txn D %s addr=%h cycle=%0d", e.wr ? "write" : "read", e.addr, c);
                end
            end
            if (c == 4) begin
                checks++; if ({ic_if.ready, dc_if.ready} !== 2'b01) begin failures++; $display("FAIL wb_write_ready: got ic/dc=%b required 01", {ic_if.ready, dc_if.ready}); end
            end
            if (c == 7) begin
                checks++; if ({ic_if.ready, dc_if.ready} !== 2'b01) begin failures++; $display("FAIL wb_refill_ready: got ic/dc=%b required 01", {ic_if.ready, dc_if.ready}); end
            end
            if (c == 8) begin
                checks++; if (mem_if.read !== 1'b0) begin failures++; $display("FAIL wb_release: got mem_read=%b required 0", mem_if.read); end
            end
            if (c == 9) begin
                checks++;
                if (ic_q.size() == 0) begin failures++; $display("FAIL wb_sb_i: got grant, required a queued I entry"); end
                else begin
                    e = ic_q.pop_front();
                    if ({mem_if.read, mem_if.write, mem_if.addr} !== {~e.wr, e.wr, e.addr}) begin
                        failures++; $display("FAIL wb_grant_i: got rd=%b wr=%b addr=%h required rd=%b wr=%b addr=%h", mem_if.read, mem_if.write, mem_if.addr, ~e.wr, e.wr, e.addr);
                    end else $display("txn I read addr=%h cycle=%0d", e.addr, c);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_isolation();
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            step();
            if (c == 0) begin
                dc_if.read = 1; dc_if.addr = 28'h0000500;
                ic_if.addr = 28'h0000600;
                dc_q.push_back('{wr: 1'b0, addr: 28'h0000500, wdata: '0});
            end else if (c <= 6) begin
                ic_if.read = c[0];
                mem_if.ready = (c == 6);
            end else begin
                dc_if.read = 0; mem_if.ready = 0;
            end
            #4;
            if (c == 1) begin
                checks++;
                if (dc_q.size() == 0) begin failures++; $display("FAIL iso_sb: got grant, required a queued D entry"); end
                else begin
                    e = dc_q.pop_front();
                    if ({mem_if.read, mem_if.addr} !== {1'b1, e.addr}) begin
                        failures++; $display("FAIL iso_grant: got rd=%b addr=%h required rd=1 addr=%h", mem_if.read, mem_if.addr, e.addr);
                    end else $display("txn D read addr=%h cycle=%0d", e.addr, c);
                end
            end
            if ((c >= 2) && (c <= 6)) begin
                checks++; if (mem_if.addr !== 28'h0000500) begin failures++; $display("FAIL iso_addr c%0d: got %h required 0000500", c, mem_if.addr); end
                checks++; if ({ic_if.ready, dc_if.ready} !== {1'b0, c == 6}) begin failures++; $display("FAIL iso_ready c%0d: got ic/dc=%b required %b", c, {ic_if.ready, dc_if.ready}, {1'b0, c == 6}); end
            end
        end
        checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL iso_err: got %b required 0", mem_err); end
        clear_inputs();
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            step();
            if (c == 0) begin
                ic_if.read = 1;  ic_if.addr = 28'h0000050;
                ic0_if.read = 1; ic0_if.addr = 28'h0000050;
                ic_q.push_back('{wr: 1'b0, addr: 28'h0000050, wdata: '0});
            end
            if (c == 12) begin mem_if.ready = 1; mem0_if.ready = 1; end
            if (c == 13) begin
                mem_if.ready = 0; mem0_if.ready = 0;
                ic_if.read = 0;   ic0_if.read = 0;
            end
            #4;
            if (c == 1) begin
                checks++;
                if (ic_q.size() == 0) begin failures++; $display("FAIL wd_sb: got grant, required a queued I entry"); end
                else begin
                    e = ic_q.pop_front();
                    if ({mem_if.read, mem_if.addr} !== {1'b1, e.addr}) begin
                        failures++; $display("FAIL wd_grant: got rd=%b addr=%h required rd=1 addr=%h", mem_if.read, mem_if.addr, e.addr);
                    end else $display("txn I read addr=%h cycle=%0d", e.addr, c);
                end
            end
            if (c >= 1) begin
                checks++; if (mem_err !== (c >= 9)) begin failures++; $display("FAIL wd_err8 c%0d: got %b required %b", c, mem_err, c >= 9); end
                checks++; if (mem_err0 !== 1'b0) begin failures++; $display("FAIL wd_err0 c%0d: got %b required 0", c, mem_err0); end
            end
            if (c == 11) begin
                checks++; if (mem_if.read !== 1'b1) begin failures++; $display("FAIL wd_hold: got mem_read=%b required 1", mem_if.read); end
            end
            if (c == 12) begin
                checks++; if (ic_if.ready !== 1'b1) begin failures++; $display("FAIL wd_late_ready: got %b required 1", ic_if.ready); end
            end
        end
        clear_inputs();
    endtask

    // Starts with mem_err still set from the watchdog scenario.
    task automatic test_reset_mid();
        for (int c = 0; c <= 8; c++) begin
            step();
            case (c)
                0: begin
                    dc_if.read = 1; dc_if.addr = 28'h0000700;
                    dc_q.push_back('{wr: 1'b0, addr: 28'h0000700, wdata: '0});
                end
                3: proc_reset = 1;
                4: begin
                    proc_reset = 0;
                    mem_if.ready = 1;
                    ic_if.read = 1; ic_if.addr = 28'h0000780;
                    dc_q.push_back('{wr: 1'b0, addr: 28'h0000700, wdata: '0});
                end
                5: mem_if.ready = 0;
                6: mem_if.ready = 1;
                7: begin mem_if.ready = 0; dc_if.read = 0; end
                default: ;
            endcase
            #4;
            if ((c == 1) || (c == 5)) begin
                checks++;
                if (dc_q.size() == 0) begin failures++; $display("FAIL rm_sb c%0d: got grant, required a queued D entry", c); end
                else begin
                    e = dc_q.pop_front();
                    if ({mem_if.read, mem_if.addr} !== {1'b1, e.addr}) begin
                        failures++; $display("FAIL rm_grant c%0d: got rd=%b addr=%h required rd=1 addr=%h", c, mem_if.read, mem_if.addr, e.addr);
                    end else $display("txn D read addr=%h cycle=%0d", e.addr, c);
                end
            end
            if (c == 2) begin
                checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL rm_err_sticky: got %b required 1", mem_err); end
            end
            if (c == 4) begin
                checks++; if ({mem_if.read, mem_if.write} !== 2'b00) begin failures++; $display("FAIL rm_req: got rd/wr=%b required 00", {mem_if.read, mem_if.write}); end
                checks++; if ({ic_if.ready, dc_if.ready} !== 2'b00) begin failures++; $display("FAIL rm_ready_idle: got ic/dc=%b required 00", {ic_if.ready, dc_if.ready}); end
                checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL rm_err: got %b required 0", mem_err); end
            end
            if (c == 6) begin
                checks++; if ({ic_if.ready, dc_if.ready} !== 2'b01) begin failures++; $display("FAIL rm_ready_d: got ic/dc=%b required 01", {ic_if.ready, dc_if.ready}); end
            end
        end
        clear_inputs();
    endtask

    initial begin
        proc_reset = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_writeback_refill();
        test_isolation();
        test_watchdog();
        test_reset_mid();
        checks++;
        if ((ic_q.size() + dc_q.size()) != 0) begin
            failures++; $display("FAIL sb_leftover: got %0d unmatched entries required 0", ic_q.size() + dc_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 128-bit block-memory interface between the instruction cache and the data cache. It sits between the two cache instances' `mem_*` ports and external memory. It grants one cache at a time, alternating on contention. It holds a grant across a dirty write-back and its following refill so that the victim/refill pair is never split. A watchdog flags a memory that fails to answer.

## Interface
- `TIMEOUT`, 1023: cycles a granted transaction may wait for `mem_ready` before `mem_err` sets; a value of 0 disables the watchdog.
- `clk`  in  1  clock.
- `proc_reset`  in  1  synchronous, active-high reset.
- `ic_mem_read`, `ic_mem_write`  in  1 each  I-cache requests.
- `ic_mem_addr`  in  28  I-cache block address.
- `ic_mem_wdata`  in  128  I-cache write data.
- `ic_mem_rdata`  out  128  read data to the I-cache.
- `ic_mem_ready`  out  1  completion strobe to the I-cache.
- `dc_mem_read`, `dc_mem_write`, `dc_mem_addr`, `dc_mem_wdata`, `dc_mem_rdata`, `dc_mem_ready`: same as the `ic_` ports, for the D-cache.
- `mem_read`, `mem_write`  out  1 each  requests to memory.
- `mem_addr`  out  28  block address to memory.
- `mem_wdata`  out  128  write data to memory.
- `mem_rdata`  in  128  read data from memory.
- `mem_ready`  in  1  completion strobe from memory; a single-cycle pulse.
- `mem_err`  out  1  sticky watchdog flag.

## Operation
- The FSM has three states: IDLE, GNT_I and GNT_D. It also keeps a `last` bit recording the most recent grantee (0 = I, 1 = D).
- A port requests when its read OR write input is high.
- **IDLE:**
  - Only I requests: go to GNT_I.
  - Only D requests: go to GNT_D.
  - Both request: grant the port that is not `last`.
  - `last` updates on entry to a grant state.
- **GNT_x:** the owner's read, write, addr and wdata pass combinationally to memory. The non-owner sees nothing forwarded, and its ready output is 0.
- **`mem_ready` in GNT_x:**
  - Pulse `x_mem_ready` in the same cycle.
  - If the completing access was a write, stay in GNT_x so the cache's refill read follows under the same grant.
  - If it was a read, return to IDLE.
- If the owner drops both request lines without `mem_ready`, return to IDLE next cycle. This is a protocol error but is tolerated.
- `ic_mem_rdata` and `dc_mem_rdata` both equal `mem_rdata` in every state. Only the ready strobe is steered.
- `mem_ready` arriving in IDLE is ignored and is not forwarded.
- **Watchdog:**
  - A counter clears on grant entry and on each `mem_ready`.
  - It increments each cycle in GNT_x and saturates.
  - When it reaches `TIMEOUT`, `mem_err` sets and stays set until reset.
  - The arbiter keeps the grant and does not abort.
- **Reset**, including mid-transaction: state goes to IDLE, `last` to 0 and the counter to 0.
  - All outputs read 0 afterwards, including `mem_err`.
  - Exception: the rdata outputs, which always follow `mem_rdata`.

## Timing
- Arbitration costs 1 cycle. A request first visible at cycle t appears on `mem_read`/`mem_write` at t+1.
- Release costs 1 cycle. After a read's `mem_ready` at t, IDLE is at t+1 and the next grant is at t+2. The memory therefore always sees at least one idle cycle between owners.
- Write followed by refill: there is no gap beyond the cache's own turnaround. A refill read asserted at t+1 after the write's `mem_ready` at t is forwarded at t+1.
- Ready, rdata and request forwarding are combinational in the granted state, with zero added latency. No register sits on the 128-bit paths.

## Structure
- A shared package holds:
  - the state encoding (IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2);
  - `MEM_ADDR_W` = 28;
  - `MEM_DATA_W` = 128.
- One natural sub-module, `mem_arb_watchdog`. It holds the counter, the compare against `TIMEOUT` and the sticky `mem_err`. Its inputs are `clk`, `proc_reset`, `busy`, `restart` and `mem_ready`.
- The FSM and the steering logic stay in the top.

## Test plan
- **Single I read:** `ic_mem_read`=1 with addr 28'h0000010 at cycle 0.
  - `mem_read`=1 and `mem_addr`=28'h0000010 from cycle 1.
  - Memory returns 128'hA5…A5 with `mem_ready` at cycle 5: `ic_mem_ready`=1 at cycle 5, `dc_mem_ready`=0.
  - IDLE at cycle 6.
- **Simultaneous requests after reset (`last`=0):**
  - Both ports read at cycle 0: D is granted first, with `mem_addr` equal to the D address at cycle 1.
  - After D completes, I is granted 2 cycles later.
  - A subsequent simultaneous pair grants I first.
- **D write-back then refill:**
  - `dc_mem_write`=1 with addr 28'h0ABCDE0 and wdata 128'h1234…; `mem_ready` at cycle 4.
  - D asserts a read of 28'h0000120 at cycle 5; it is forwarded at cycle 5.
  - A pending I read is not granted until the cycle after the refill's `mem_ready`.
- **Non-owner isolation:**
  - While D owns, I toggles `ic_mem_read`.
  - `mem_addr` never shows the I address, and `ic_mem_ready` stays 0.
- **Watchdog:**
  - Run with `TIMEOUT`=8: grant I and withhold `mem_ready`. `mem_err` rises at cycle 8 after grant and stays high after `mem_ready` finally arrives.
  - Run with `TIMEOUT`=0: `mem_err` never rises.
- **Reset mid-transaction:**
  - Assert `proc_reset` in GNT_D at cycle 3. `mem_read`, `mem_write`, both ready outputs and `mem_err` are 0 from cycle 4.
  - After reset releases with both ports requesting, D is granted first.
